// File: rtl/pulse_flasher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_flasher_pkg
// Description : Shared definitions for the pulse_flasher block: FSM state
//               encoding, board-clock derived default flash timings and
//               small constant helpers used to size the flash timer.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_flasher_pkg;

  // FSM state encoding (2-bit; encoding 3 is unreachable and recovers to IDLE)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Default timings assume the 50 MHz board clock: 0.5 s on, 0.25 s gap.
  localparam int c_board_clk_hz       = 50_000_000;
  localparam int c_default_on_cycles  = c_board_clk_hz / 2;
  localparam int c_default_gap_cycles = c_board_clk_hz / 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0 .. n-1 (never less than one bit).
  function automatic int timer_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : pulse_flasher_pkg
`default_nettype wire

// File: rtl/pulse_flasher_flash_timer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_flasher_flash_timer
// Description : Loadable down-counter shared by the ON and GAP phases of
//               pulse_flasher. Load has priority over decrement; the counter
//               holds at zero rather than wrapping.
// Ports       : clk      - system clock
//               rst      - synchronous active-high reset (count -> 0)
//               load     - load enable
//               load_val - value loaded when load is high
//               dec      - decrement enable
//               zero     - high while the count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_flasher_flash_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign zero = (r_count == '0);

endmodule : pulse_flasher_flash_timer
`default_nettype wire

// File: rtl/pulse_flasher.sv
`default_nettype none
// ============================================================================
// Module      : pulse_flasher
// Description : Converts single-cycle event pulses into evenly spaced LED
//               flashes, one flash per pulse. Pulses arriving while a flash
//               or gap is in progress are queued in a saturating counter;
//               a pulse that finds the queue full sets a sticky Overflow.
// Ports       : clk          - system clock
//               rst          - synchronous active-high reset
//               PulseIn      - single-cycle event input
//               LedOut       - registered flash output (active-high)
//               Busy         - registered, high while in ON or GAP
//               PendingCount - registered count of queued, unserved pulses
//               Overflow     - sticky, set when a pulse is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_flasher
  import pulse_flasher_pkg::*;
#(
  parameter int ON_CYCLES   = c_default_on_cycles,
  parameter int GAP_CYCLES  = c_default_gap_cycles,
  parameter int MAX_PENDING = 7,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PulseIn,
  output logic              LedOut,
  output logic              Busy,
  output logic [PEND_W-1:0] PendingCount,
  output logic              Overflow
);

  // One timer serves both phases, so it is sized for the longer of the two.
  localparam int c_timer_w = timer_width(max_int(ON_CYCLES, GAP_CYCLES));

  localparam logic [c_timer_w-1:0] c_on_load  = c_timer_w'(ON_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_gap_load = c_timer_w'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]    c_max_pend = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0]    c_pend_one = PEND_W'(1);

  // Registered state and outputs
  state_t            r_state;
  logic              r_led;
  logic              r_busy;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;

  // Next-state / control
  state_t                 w_state_nxt;
  logic                   w_led_nxt;
  logic                   w_busy_nxt;
  logic [PEND_W-1:0]      w_pend_nxt;
  logic                   w_ovf_nxt;
  logic                   w_enqueue;
  logic                   w_tmr_load;
  logic [c_timer_w-1:0]   w_tmr_val;
  logic                   w_tmr_dec;
  logic                   w_tmr_zero;

  pulse_flasher_flash_timer #(
    .WIDTH (c_timer_w)
  ) u_flash_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .dec      (w_tmr_dec),
    .zero     (w_tmr_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state and output-next logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_ovf_nxt   = r_ovf;
    w_enqueue   = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_dec   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Pulse is served immediately; the queue is untouched.
        if (PulseIn) begin
          w_state_nxt = ST_ON;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_on_load;
        end
      end

      ST_ON: begin
        w_enqueue = PulseIn;
        if (w_tmr_zero) begin
          w_state_nxt = ST_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_gap_load;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_GAP: begin
        if (!w_tmr_zero) begin
          w_tmr_dec = 1'b1;
          w_enqueue = PulseIn;
        end else if (r_pend != '0) begin
          // Serve the oldest queued pulse; a simultaneous new pulse takes
          // its place in the queue, leaving the count unchanged.
          w_state_nxt = ST_ON;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_on_load;
          if (!PulseIn) begin
            w_pend_nxt = r_pend - c_pend_one;
          end
        end else if (PulseIn) begin
          // Empty queue: the terminal-cycle pulse starts the next flash
          // directly, with no IDLE cycle in between.
          w_state_nxt = ST_ON;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_on_load;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_enqueue) begin
      if (r_pend < c_max_pend) begin
        w_pend_nxt = r_pend + c_pend_one;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  // Outputs are derived from the next state so they are registered in
  // lockstep with the state register.
  assign w_led_nxt  = (w_state_nxt == ST_ON);
  assign w_busy_nxt = (w_state_nxt != ST_IDLE);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign LedOut       = r_led;
  assign Busy         = r_busy;
  assign PendingCount = r_pend;
  assign Overflow     = r_ovf;

endmodule : pulse_flasher
`default_nettype wire

// File: tb/tb_pulse_flasher.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_flasher
// Description : Directed self-checking bench for pulse_flasher with
//               ON_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3, PEND_W=2.
//               Each sequence is written as per-edge character strings
//               (one character per clock edge) giving the PulseIn drive and
//               the hand-derived LedOut, Busy, PendingCount and Overflow
//               values expected just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_flasher;

  logic       clk;
  logic       rst;
  logic       PulseIn;
  logic       LedOut;
  logic       Busy;
  logic [1:0] PendingCount;
  logic       Overflow;

  int n_tests;
  int n_fail;

  pulse_flasher #(
    .ON_CYCLES   (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3),
    .PEND_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PulseIn      (PulseIn),
    .LedOut       (LedOut),
    .Busy         (Busy),
    .PendingCount (PendingCount),
    .Overflow     (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset for one edge with the given PulseIn level; reset must win.
  task automatic do_reset(input string tag, input logic pulse);
    rst     = 1'b1;
    PulseIn = pulse;
    tick();
    chk({tag, ".led"},  {31'd0, LedOut},       32'd0);
    chk({tag, ".busy"}, {31'd0, Busy},         32'd0);
    chk({tag, ".pend"}, {30'd0, PendingCount}, 32'd0);
    chk({tag, ".ovf"},  {31'd0, Overflow},     32'd0);
    rst     = 1'b0;
    PulseIn = 1'b0;
  endtask

  task automatic seq(input string tag, input string pul, input string led,
                     input string bsy, input string pnd, input string ovf);
    for (int i = 0; i < pul.len(); i++) begin
      PulseIn = (pul[i] == "1");
      tick();
      chk($sformatf("%s.led[%0d]", tag, i),  {31'd0, LedOut},       (led[i] == "1") ? 32'd1 : 32'd0);
      chk($sformatf("%s.busy[%0d]", tag, i), {31'd0, Busy},         (bsy[i] == "1") ? 32'd1 : 32'd0);
      chk($sformatf("%s.pend[%0d]", tag, i), {30'd0, PendingCount}, 32'(int'(pnd[i]) - 48));
      chk($sformatf("%s.ovf[%0d]", tag, i),  {31'd0, Overflow},     (ovf[i] == "1") ? 32'd1 : 32'd0);
    end
    PulseIn = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    PulseIn = 1'b0;

    // Reset state, with a simultaneous pulse that must be ignored
    do_reset("reset", 1'b1);
    seq("idle", "000", "000", "000", "000", "000");

    // Single pulse: 4 cycles high, 2 cycles gap, then IDLE
    seq("single", "1000000", "1111000", "1111110", "0000000", "0000000");

    // Three back-to-back pulses: flashes rise at offsets 0, 6, 12
    seq("triple",
        "1110000000000000000",
        "1111001111001111000",
        "1111111111111111110",
        "0122221111110000000",
        "0000000000000000000");

    // Six pulses: one served, three queued, two dropped -> 4 flashes total
    seq("ovf",
        "1111110000000000000000000",
        "1111001111001111001111000",
        "1111111111111111111111110",
        "0123332222221111110000000",
        "0000111111111111111111111");
    seq("ovf_sticky", "00", "00", "00", "00", "11");
    do_reset("ovf_clr", 1'b0);

    // Pulse on the terminal GAP cycle with an empty queue
    seq("term0",
        "1000001000000",
        "1111001111000",
        "1111111111110",
        "0000000000000",
        "0000000000000");

    // Pulse on the terminal GAP cycle with one queued pulse
    seq("term1",
        "1100001000000000000",
        "1111001111001111000",
        "1111111111111111110",
        "0111111111110000000",
        "0000000000000000000");

    // Reset mid-ON with two queued pulses, then a normal flash
    seq("pre_rst", "111", "111", "111", "012", "000");
    do_reset("mid_rst", 1'b1);
    seq("post_rst", "1000000", "1111000", "1111110", "0000000", "0000000");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulse_flasher
`default_nettype wire
